// File: rtl/seg_pkg.sv
// Shared constants, segment encoder and FSM states for the
// signed decimal 7-segment axis display.
package seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_MINUS = 7'h3F;
    localparam logic [6:0] SEG_ZERO  = 7'h40;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        LOAD = 2'd2
    } state_t;

    // Active-low {g..a}; non-decimal codes light nothing.
    function automatic logic [6:0] seg_encode(input logic [3:0] i_bcd);
        logic [6:0] v_seg;
        case (i_bcd)
            4'd0:    v_seg = 7'h40;
            4'd1:    v_seg = 7'h79;
            4'd2:    v_seg = 7'h24;
            4'd3:    v_seg = 7'h30;
            4'd4:    v_seg = 7'h19;
            4'd5:    v_seg = 7'h12;
            4'd6:    v_seg = 7'h02;
            4'd7:    v_seg = 7'h78;
            4'd8:    v_seg = 7'h00;
            4'd9:    v_seg = 7'h10;
            default: v_seg = SEG_BLANK;
        endcase
        return v_seg;
    endfunction

endpackage

// File: rtl/seg_bcd_conv.sv
// Iterative double-dabble: one magnitude bit per cycle, MSB first.
// i_start loads a new magnitude; o_done pulses after the last shift.
module seg_bcd_conv #(
    parameter int MAG_W      = 10,
    parameter int NUM_DIGITS = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [MAG_W-1:0]        i_mag,
    output logic [4*NUM_DIGITS-1:0] o_bcd,
    output logic                    o_done
);

    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(MAG_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(MAG_W - 1);

    logic [MAG_W-1:0] r_mag;
    logic [BCD_W-1:0] r_bcd;
    logic [CNT_W-1:0] r_cnt;
    logic             r_run;
    logic             r_done;
    logic [BCD_W-1:0] w_adj;

    // Add-3 correction on every nibble that would overflow when doubled.
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    // Shift engine: load on start, then MAG_W correct-and-shift steps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mag  <= '0;
            r_bcd  <= '0;
            r_cnt  <= '0;
            r_run  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_start) begin
                r_mag <= i_mag;
                r_bcd <= '0;
                r_cnt <= '0;
                r_run <= 1'b1;
            end else if (r_run) begin
                r_bcd <= {w_adj[BCD_W-2:0], r_mag[MAG_W-1]};
                r_mag <= {r_mag[MAG_W-2:0], 1'b0};
                r_cnt <= r_cnt + 1'b1;
                if (r_cnt == LAST) begin
                    r_run  <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_bcd  = r_bcd;
    assign o_done = r_done;

endmodule

// File: rtl/seg_axis_display.sv
// Signed decimal 7-segment driver for one accelerometer axis, with an
// interrupt-triggered display freeze. Define SEG_BLINK_EN to blink while frozen.
module seg_axis_display
    import seg_pkg::*;
#(
    parameter int DATA_W     = 10,
    parameter int SHIFT      = 0,
    parameter int NUM_DIGITS = 3,
    parameter int HOLD_LOG2  = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       sample,
    input  logic                    sample_valid,
    input  logic                    int_in,
    output logic [7*NUM_DIGITS-1:0] hex_digits,
    output logic [6:0]              hex_sign,
    output logic                    busy,
    output logic                    event_active
);

    localparam int MAG_W   = DATA_W - SHIFT;
    localparam int BCD_W   = 4 * NUM_DIGITS;
    localparam int MAX_DEC = 10 ** NUM_DIGITS - 1;

    state_t r_state;
    state_t w_next;

    logic                    r_neg;
    logic [7*NUM_DIGITS-1:0] r_hex_digits;
    logic [6:0]              r_hex_sign;
    logic                    r_sync1;
    logic                    r_sync2;
    logic                    r_sync3;
    logic                    r_event;
    logic [HOLD_LOG2-1:0]    r_hold_cnt;

    logic [MAG_W-1:0]        w_s;
    logic                    w_neg;
    logic [MAG_W-1:0]        w_abs;
    logic [MAG_W-1:0]        w_mag;
    logic [BCD_W-1:0]        w_bcd;
    logic                    w_done;
    logic                    w_busy;
    logic                    w_start;
    logic                    w_load;
    logic                    w_int_edge;
    logic                    w_seen;
    logic [7*NUM_DIGITS-1:0] w_disp;

    // Sign/magnitude split and clamp of the incoming sample.
    always_comb begin
        w_s   = MAG_W'($signed(sample) >>> SHIFT);
        w_neg = w_s[MAG_W-1];
        w_abs = w_neg ? (~w_s + 1'b1) : w_s;
        if (32'(w_abs) > 32'(MAX_DEC))
            w_mag = MAG_W'(MAX_DEC);
        else
            w_mag = w_abs;
    end

    seg_bcd_conv #(
        .MAG_W      (MAG_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_start),
        .i_mag   (w_mag),
        .o_bcd   (w_bcd),
        .o_done  (w_done)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // FSM next state: capture, wait for the converter, one load cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (sample_valid) w_next = CONV;
            CONV:    if (w_done) w_next = LOAD;
            LOAD:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // FSM outputs; a fresh interrupt edge already counts as frozen.
    always_comb begin
        w_busy  = (r_state != IDLE);
        w_start = (r_state == IDLE) && sample_valid;
        w_load  = (r_state == LOAD) && !r_event && !w_int_edge;
    end

    // Sign is latched at capture; a clamped zero never shows a minus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_neg <= 1'b0;
        else if (w_start)
            r_neg <= w_neg && (w_mag != '0);
    end

    // Encode digits, blanking zeros above the most significant non-zero.
    always_comb begin
        w_seen = 1'b0;
        w_disp = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (w_bcd[4*i +: 4] != 4'd0)
                w_seen = 1'b1;
            if (w_seen || i == 0)
                w_disp[7*i +: 7] = seg_encode(w_bcd[4*i +: 4]);
            else
                w_disp[7*i +: 7] = SEG_BLANK;
        end
    end

    // Display registers: digits and sign change together on an unfrozen load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hex_digits      <= {NUM_DIGITS{SEG_BLANK}};
            r_hex_digits[6:0] <= SEG_ZERO;
            r_hex_sign        <= SEG_BLANK;
        end else if (w_load) begin
            r_hex_digits <= w_disp;
            r_hex_sign   <= r_neg ? SEG_MINUS : SEG_BLANK;
        end
    end

    // Two-flop synchroniser plus a delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_sync3 <= 1'b0;
        end else begin
            r_sync1 <= int_in;
            r_sync2 <= r_sync1;
            r_sync3 <= r_sync2;
        end
    end

    assign w_int_edge = r_sync2 & ~r_sync3;

    // Hold timer: an edge (re)starts the window, which ends after 2^HOLD_LOG2 cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_event    <= 1'b0;
            r_hold_cnt <= '0;
        end else if (w_int_edge) begin
            r_event    <= 1'b1;
            r_hold_cnt <= '0;
        end else if (r_event) begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
            if (&r_hold_cnt)
                r_event <= 1'b0;
        end
    end

`ifdef SEG_BLINK_EN
    logic w_blink;
    assign w_blink    = r_event & r_hold_cnt[HOLD_LOG2-3];
    assign hex_digits = w_blink ? {NUM_DIGITS{SEG_BLANK}} : r_hex_digits;
    assign hex_sign   = w_blink ? SEG_BLANK : r_hex_sign;
`else
    assign hex_digits = r_hex_digits;
    assign hex_sign   = r_hex_sign;
`endif

    assign busy         = w_busy;
    assign event_active = r_event;

endmodule
